// File: rtl/my_interpolator_pipe.sv
// Three-stage linear interpolator: base + ((next_data - base) * remaining) >>> FRAC_W.
// One global stall freezes every stage while the output is held by downstream.
module my_interpolator_pipe #(
    parameter int DATA_W   = 8,
    parameter int FRAC_W   = 4,
    parameter int SATURATE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] base,
    input  logic signed [DATA_W-1:0] next_data,
    input  logic signed [DATA_W-1:0] remaining,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] interpolated_value,
    output logic                     sat_flag,
    output logic [15:0]              sat_count,
    input  logic                     sat_clr
);
    localparam int DW = DATA_W + 1;
    localparam int PW = 2*DATA_W + 1;
    localparam int SW = 2*DATA_W + 2;
    localparam logic signed [SW-1:0] MAX_V = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_V = ~MAX_V;

    logic [3:1]               vld_pipe_q;
    logic                     stall;
    logic                     deliver;

    logic signed [DW-1:0]     s1_diff_q, s1_diff_d;
    logic signed [DATA_W-1:0] s1_base_q, s1_rem_q;
    logic signed [PW-1:0]     s2_prod_q, s2_prod_d;
    logic signed [DATA_W-1:0] s2_base_q;
    logic signed [DATA_W-1:0] res_q, res_d;
    logic                     sat_q, sat_d;
    logic [15:0]              cnt_q, cnt_d;

    logic signed [PW-1:0]     diff_x, rem_x, shifted;
    logic signed [SW-1:0]     sum;

    assign stall              = vld_pipe_q[3] && !out_ready;
    assign deliver            = vld_pipe_q[3] && out_ready;
    assign in_ready           = !stall;
    assign out_valid          = vld_pipe_q[3];
    assign interpolated_value = res_q;
    assign sat_flag           = sat_q;
    assign sat_count          = cnt_q;

    assign s1_diff_d = DW'(next_data) - DW'(base);

    always_comb begin
        diff_x    = PW'(s1_diff_q);
        rem_x     = PW'(s1_rem_q);
        s2_prod_d = diff_x * rem_x;
    end

    // Arithmetic shift floors toward minus infinity; the sum is wide enough to never overflow.
    always_comb begin
        shifted = s2_prod_q >>> FRAC_W;
        sum     = SW'(s2_base_q) + SW'(shifted);
        res_d   = sum[DATA_W-1:0];
        sat_d   = (sum > MAX_V) || (sum < MIN_V);
        if (SATURATE != 0) begin
            if (sum > MAX_V)      res_d = MAX_V[DATA_W-1:0];
            else if (sum < MIN_V) res_d = MIN_V[DATA_W-1:0];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (sat_clr)                              cnt_d = '0;
        else if (deliver && sat_q && cnt_q != '1) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            s1_diff_q  <= '0;
            s1_base_q  <= '0;
            s1_rem_q   <= '0;
            s2_prod_q  <= '0;
            s2_base_q  <= '0;
            res_q      <= '0;
            sat_q      <= 1'b0;
        end else if (!stall) begin
            vld_pipe_q <= {vld_pipe_q[2:1], in_valid};
            // Data registers only load behind a valid token, so bubbles never leak stale operands.
            if (in_valid) begin
                s1_diff_q <= s1_diff_d;
                s1_base_q <= base;
                s1_rem_q  <= remaining;
            end
            if (vld_pipe_q[1]) begin
                s2_prod_q <= s2_prod_d;
                s2_base_q <= s1_base_q;
            end
            if (vld_pipe_q[2]) begin
                res_q <= res_d;
                sat_q <= sat_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: tb/tb_my_interpolator_pipe.sv
// Bench for my_interpolator_pipe: directed scenarios plus random traffic, with a
// queue-based arithmetic reference for both the clamping and the wrapping build.
module tb_my_interpolator_pipe;
    localparam int DATA_W = 8;
    localparam int FRAC_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic sat_clr = 1'b0;
    logic signed [DATA_W-1:0] base = '0, next_data = '0, remaining = '0;

    logic in_ready, out_valid, sat_flag;
    logic signed [DATA_W-1:0] interpolated_value;
    logic [15:0] sat_count;
    logic w_in_ready, w_out_valid, w_sat_flag;
    logic signed [DATA_W-1:0] w_value;
    logic [15:0] w_sat_count;

    my_interpolator_pipe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .base(base), .next_data(next_data), .remaining(remaining),
        .out_valid(out_valid), .out_ready(out_ready),
        .interpolated_value(interpolated_value), .sat_flag(sat_flag),
        .sat_count(sat_count), .sat_clr(sat_clr));

    my_interpolator_pipe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .base(base), .next_data(next_data), .remaining(remaining),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .interpolated_value(w_value), .sat_flag(w_sat_flag),
        .sat_count(w_sat_count), .sat_clr(sat_clr));

    always #5 clk = ~clk;

    typedef struct {
        int v_s, f_s, v_w, f_w;
        int acc_cyc, acc_stall;
    } item_t;

    item_t sb[$];
    int total = 0, bad = 0;
    int cyc_n = 0, stall_total = 0, dlv_cnt = 0, cnt_s = 0, cnt_w = 0;
    int dlv_val = 0, dlv_flag = 0, dlv_wval = 0, dlv_wflag = 0, dlv_cyc = 0;
    int prev_val = 0, prev_flag = 0;
    bit acc_last = 0, prev_stall = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference arithmetic: exact integer product, floor division, then clamp or modulo.
    function automatic void model(input int b, input int n, input int r,
                                  output int vs, output int fs, output int vw, output int fw);
        int prod, den, q, sum, hi, lo, md;
        hi   = (1 << (DATA_W-1)) - 1;
        lo   = -(1 << (DATA_W-1));
        md   = 1 << DATA_W;
        prod = (n - b) * r;
        den  = 1 << FRAC_W;
        q    = prod / den;
        if (prod < 0 && (prod % den) != 0) q = q - 1;
        sum  = b + q;
        fs   = (sum > hi || sum < lo) ? 1 : 0;
        fw   = fs;
        vs   = (sum > hi) ? hi : (sum < lo) ? lo : sum;
        vw   = ((sum % md) + md) % md;
        if (vw > hi) vw = vw - md;
    endfunction

    task automatic mon();
        bit stall, dlv;
        item_t it;
        @(negedge clk);
        stall = out_valid && !out_ready;
        chk("in_ready", in_ready, !stall);
        chk("wrap_in_ready", w_in_ready, in_ready);
        chk("wrap_out_valid", w_out_valid, out_valid);
        chk("sat_count", sat_count, cnt_s);
        chk("wrap_sat_count", w_sat_count, cnt_w);
        if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_value", interpolated_value, prev_val);
            chk("hold_flag", sat_flag, prev_flag);
        end
        dlv = out_valid && out_ready;
        acc_last = in_valid && in_ready;
        if (dlv) begin
            if (sb.size() == 0) begin
                chk("spurious_output", out_valid, 0);
                it = '{default: 0};
            end else begin
                it = sb.pop_front();
                chk("value", interpolated_value, it.v_s);
                chk("flag", sat_flag, it.f_s);
                chk("wrap_value", w_value, it.v_w);
                chk("wrap_flag", w_sat_flag, it.f_w);
                chk("latency", cyc_n - it.acc_cyc, 3 + stall_total - it.acc_stall);
            end
            dlv_cnt++;
            dlv_val = int'(interpolated_value);
            dlv_flag = int'(sat_flag);
            dlv_wval = int'(w_value);
            dlv_wflag = int'(w_sat_flag);
            dlv_cyc = cyc_n;
        end
        if (sat_clr) begin
            cnt_s = 0;
            cnt_w = 0;
        end else if (dlv) begin
            if (it.f_s != 0 && cnt_s < 65535) cnt_s++;
            if (it.f_w != 0 && cnt_w < 65535) cnt_w++;
        end
        if (acc_last) begin
            model(int'(base), int'(next_data), int'(remaining), it.v_s, it.f_s, it.v_w, it.f_w);
            it.acc_cyc = cyc_n;
            it.acc_stall = stall_total;
            sb.push_back(it);
        end
        if (stall) stall_total++;
        prev_stall = stall;
        prev_val = int'(interpolated_value);
        prev_flag = int'(sat_flag);
    endtask

    task automatic cyc();
        mon();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic put(input int b, input int n, input int r);
        base = DATA_W'(b);
        next_data = DATA_W'(n);
        remaining = DATA_W'(r);
        in_valid = 1'b1;
    endtask

    task automatic send(input int b, input int n, input int r);
        int k;
        put(b, n, r);
        k = 0;
        do begin
            cyc();
            k++;
        end while (!acc_last && k < 20);
        chk("accept_timeout", acc_last, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic drain();
        int k;
        in_valid = 1'b0;
        out_ready = 1'b1;
        sat_clr = 1'b0;
        k = 0;
        while ((sb.size() != 0 || out_valid) && k < 50) begin
            cyc();
            k++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    // Streams n random items; out_ready drops on relative cycles lo..hi.
    task automatic stream(input int n, input int lo, input int hi);
        int idx, c0, k;
        c0 = cyc_n;
        idx = 0;
        k = 0;
        put($urandom, $urandom, $urandom);
        while (idx < n && k < 200) begin
            out_ready = !((cyc_n - c0) >= lo && (cyc_n - c0) <= hi);
            cyc();
            k++;
            if (acc_last) begin
                idx++;
                put($urandom, $urandom, $urandom);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int c0, d0;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_value", interpolated_value, 0);
        chk("rst_flag", sat_flag, 0);
        chk("rst_count", sat_count, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        c0 = cyc_n;
        send(10, 26, 8);
        idle(4);
        chk("s1_value", dlv_val, 18);
        chk("s1_flag", dlv_flag, 0);
        chk("s1_latency", dlv_cyc - c0, 3);

        send(20, 4, 4);
        idle(4);
        chk("s2_value", dlv_val, 16);
        send(0, 1, -1);
        idle(4);
        chk("s2_floor", dlv_val, -1);

        send(100, 127, 127);
        idle(4);
        chk("s3_clamp", dlv_val, 127);
        chk("s3_clamp_flag", dlv_flag, 1);
        chk("s3_wrap", dlv_wval, 58);
        chk("s3_wrap_flag", dlv_wflag, 1);
        chk("s3_count", sat_count, 1);

        c0 = cyc_n;
        send(100, 127, 127);
        idle(2);
        sat_clr = 1'b1;
        cyc();
        sat_clr = 1'b0;
        chk("clr_same_cycle", dlv_cyc - c0, 3);
        chk("clr_delivered_sat", dlv_flag, 1);
        chk("clr_count", sat_count, 0);
        chk("clr_wrap_count", w_sat_count, 0);

        c0 = cyc_n;
        d0 = dlv_cnt;
        stream(10, 1000, 1000);
        drain();
        chk("b2b_count", dlv_cnt - d0, 10);
        chk("b2b_last_cycle", dlv_cyc - c0, 12);

        c0 = cyc_n;
        d0 = dlv_cnt;
        stream(10, 5, 7);
        drain();
        chk("stall_count", dlv_cnt - d0, 10);
        chk("stall_last_cycle", dlv_cyc - c0, 15);

        // Three items in flight with the head held at the output, then an unclocked reset pulse.
        out_ready = 1'b0;
        send(1, 2, 3);
        send(4, 5, 6);
        send(7, 8, 9);
        chk("pre_rst_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_value", interpolated_value, 0);
        chk("mid_rst_flag", sat_flag, 0);
        chk("mid_rst_count", sat_count, 0);
        rst_n = 1'b1;
        sb.delete();
        cnt_s = 0;
        cnt_w = 0;
        prev_stall = 0;
        out_ready = 1'b1;
        d0 = dlv_cnt;
        idle(8);
        chk("post_rst_no_output", dlv_cnt - d0, 0);
        c0 = cyc_n;
        send(10, 26, 8);
        idle(4);
        chk("post_rst_latency", dlv_cyc - c0, 3);
        chk("post_rst_value", dlv_val, 18);

        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            base = DATA_W'($urandom);
            next_data = DATA_W'($urandom);
            remaining = DATA_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            sat_clr = ($urandom_range(0, 31) == 0);
            cyc();
        end
        drain();

        put(100, 127, 127);
        out_ready = 1'b1;
        repeat (65540) cyc();
        drain();
        chk("count_ceiling", sat_count, 16'hFFFF);
        chk("wrap_count_ceiling", w_sat_count, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
